// File: rtl/pio_irq_service_master_pkg.sv
// Shared definitions for the PIO edge-capture service master:
// register offsets and FSM state encoding.
package pio_irq_service_master_pkg;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE = 3'd3;
  localparam logic [2:0] REG_SET  = 3'd4;
  localparam logic [2:0] REG_CLR  = 3'd5;

  typedef enum logic [2:0] {
    INIT_MASK,
    CLR_ALL,
    HOLDOFF,
    WAIT_IRQ,
    RD_CAP,
    RD_WAIT,
    CLR_CAP,
    PUSH
  } state_t;

endpackage

// File: rtl/pio_irq_service_master.sv
// Avalon-MM host that masks, reads and clears an edge-capture PIO
// and forwards each captured word as one event on a valid/ready stream.
module pio_irq_service_master
  import pio_irq_service_master_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int IRQ_HOLDOFF  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_mask_upd,
  input  logic              irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [15:0]       evt_count,
  output logic              busy
);

  localparam logic [3:0] HOLD_LOAD = 4'(IRQ_HOLDOFF - 1);
  localparam logic [3:0] RD_LOAD   = 4'(READ_LATENCY);

  state_t state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              pending, pending_n;
  logic [DATA_W-1:0] cap, cap_n;
  logic [2:0]        address_n;
  logic              cs_n, wr_n_n;
  logic [DATA_W-1:0] wd_n;
  logic              evt_valid_n;
  logic [DATA_W-1:0] evt_data_n;
  logic [15:0]       evt_count_n;
  logic              busy_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= INIT_MASK;
      cnt            <= '0;
      pending        <= 1'b0;
      cap            <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      evt_valid      <= 1'b0;
      evt_data       <= '0;
      evt_count      <= '0;
      busy           <= 1'b1;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      pending        <= pending_n;
      cap            <= cap_n;
      avm_address    <= address_n;
      avm_chipselect <= cs_n;
      avm_write_n    <= wr_n_n;
      avm_writedata  <= wd_n;
      evt_valid      <= evt_valid_n;
      evt_data       <= evt_data_n;
      evt_count      <= evt_count_n;
      busy           <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pending_n   = pending | (cfg_mask_upd && state != WAIT_IRQ);
    cap_n       = cap;
    address_n   = '0;
    cs_n        = 1'b0;
    wr_n_n      = 1'b1;
    wd_n        = '0;
    evt_valid_n = evt_valid;
    evt_data_n  = evt_data;
    evt_count_n = evt_count;
    unique case (state)
      INIT_MASK: begin
        cs_n      = 1'b1;
        wr_n_n    = 1'b0;
        address_n = REG_MASK;
        wd_n      = cfg_mask;
        pending_n = 1'b0;
        state_n   = CLR_ALL;
      end
      CLR_ALL: begin
        cs_n      = 1'b1;
        wr_n_n    = 1'b0;
        address_n = REG_EDGE;
        wd_n      = '1;
        cnt_n     = HOLD_LOAD;
        state_n   = HOLDOFF;
      end
      HOLDOFF: begin
        if (cnt == 4'd0) state_n = WAIT_IRQ;
        else             cnt_n   = cnt - 4'd1;
      end
      WAIT_IRQ: begin
        // a mask rewrite takes priority over servicing irq
        if (pending || cfg_mask_upd) state_n = INIT_MASK;
        else if (irq)                state_n = RD_CAP;
      end
      RD_CAP: begin
        cs_n      = 1'b1;
        address_n = REG_EDGE;
        cnt_n     = RD_LOAD;
        state_n   = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          cap_n = avm_readdata;
          if (avm_readdata == '0) begin
            cnt_n   = HOLD_LOAD;
            state_n = HOLDOFF;
          end else begin
            state_n = CLR_CAP;
          end
        end
      end
      CLR_CAP: begin
        // re-arm the PIO before the consumer sees the event
        cs_n        = 1'b1;
        wr_n_n      = 1'b0;
        address_n   = REG_EDGE;
        wd_n        = cap;
        evt_valid_n = 1'b1;
        evt_data_n  = cap;
        state_n     = PUSH;
      end
      PUSH: begin
        if (evt_ready) begin
          evt_valid_n = 1'b0;
          evt_count_n = evt_count + 16'd1;
          cnt_n       = HOLD_LOAD;
          state_n     = HOLDOFF;
        end
      end
      default: state_n = INIT_MASK;
    endcase
    busy_n = (state_n != WAIT_IRQ);
  end

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Directed bench for pio_irq_service_master against a small
// edge-capture PIO slave model with registered readdata.
module tb_pio_irq_service_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cfg_mask;
  logic        cfg_mask_upd;
  logic        irq;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_data;
  logic [15:0] evt_count;
  logic        busy;

  logic [31:0] in_port, in_prev, pio_edge, pio_mask;
  logic        irq_force;
  logic [35:0] bus_log[$];
  logic [31:0] evt_log[$];

  int checks = 0;
  int errors = 0;
  int n;
  int cyc;
  int unstable;

  pio_irq_service_master #(
    .DATA_W(32), .READ_LATENCY(1), .IRQ_HOLDOFF(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_mask(cfg_mask), .cfg_mask_upd(cfg_mask_upd), .irq(irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  assign irq = (|(pio_edge & pio_mask)) | irq_force;

  always @(posedge clk) begin
    logic [31:0] clr;
    clr = (avm_chipselect && !avm_write_n && avm_address == 3'd3)
          ? avm_writedata : 32'h0;
    pio_edge <= (pio_edge & ~clr) | (in_port & ~in_prev);
    in_prev  <= in_port;
    if (avm_chipselect && !avm_write_n && avm_address == 3'd2)
      pio_mask <= avm_writedata;
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 3'd3) ? pio_edge :
                      (avm_address == 3'd2) ? pio_mask :
                      (avm_address == 3'd0) ? in_port : 32'h0;
    if (avm_chipselect)
      bus_log.push_back({~avm_write_n, avm_address, avm_writedata});
    if (evt_valid && evt_ready)
      evt_log.push_back(evt_data);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] log_at(input int i);
    if (i < bus_log.size()) return {28'h0, bus_log[i]};
    return 64'hDEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] evt_at(input int i);
    if (i < evt_log.size()) return {32'h0, evt_log[i]};
    return 64'hDEAD_DEAD_DEAD;
  endfunction

  initial begin
    reset_n = 1'b0; cfg_mask = 32'hFF; cfg_mask_upd = 1'b0;
    evt_ready = 1'b0; in_port = '0; in_prev = '0;
    pio_edge = '0; pio_mask = '0; irq_force = 1'b0; avm_readdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_busy", busy, 1);

    // 1: init sequence and holdoff
    reset_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    chk("init_busy_cycles", cyc, 4);
    chk("init_nlog", bus_log.size(), 2);
    chk("init_wr_mask", log_at(0), {28'h0, 1'b1, 3'd2, 32'hFF});
    chk("init_wr_clr", log_at(1), {28'h0, 1'b1, 3'd3, 32'hFFFF_FFFF});

    // 2: single edge, consumer ready
    evt_ready = 1'b1;
    in_port = 32'h8;
    for (int i = 0; i < 100 && evt_count != 16'd1; i++) @(negedge clk);
    chk("e1_count", evt_count, 1);
    chk("e1_read", log_at(2), {28'h0, 1'b0, 3'd3, 32'h0});
    chk("e1_clear", log_at(3), {28'h0, 1'b1, 3'd3, 32'h8});
    chk("e1_data", evt_at(0), 32'h8);

    // 3: stalled consumer, new edge arrives during the stall
    in_port = 32'h0;
    repeat (3) @(negedge clk);
    evt_ready = 1'b0;
    in_port = 32'h8;
    for (int i = 0; i < 100 && !evt_valid; i++) @(negedge clk);
    chk("e2_valid", evt_valid, 1);
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) in_port = 32'h28;
      if (!evt_valid || evt_data !== 32'h8) unstable++;
      @(negedge clk);
    end
    chk("e2_stable", unstable, 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 100 && evt_count != 16'd3; i++) @(negedge clk);
    chk("e3_count", evt_count, 3);
    chk("e2_data", evt_at(1), 32'h8);
    chk("e3_data", evt_at(2), 32'h20);
    chk("e3_clear", log_at(bus_log.size() - 1), {28'h0, 1'b1, 3'd3, 32'h20});

    // 4: spurious irq
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    n = bus_log.size();
    irq_force = 1'b1;
    for (int i = 0; i < 50 && bus_log.size() <= n; i++) @(negedge clk);
    irq_force = 1'b0;
    repeat (20) @(negedge clk);
    chk("sp_nlog", bus_log.size(), n + 1);
    chk("sp_read", log_at(n), {28'h0, 1'b0, 3'd3, 32'h0});
    chk("sp_count", evt_count, 3);
    chk("sp_idle", busy, 0);

    // 5: mask update requested while an event is pushed
    evt_ready = 1'b0;
    in_port = 32'h0;
    repeat (3) @(negedge clk);
    in_port = 32'h8;
    for (int i = 0; i < 100 && !evt_valid; i++) @(negedge clk);
    cfg_mask = 32'h0F; cfg_mask_upd = 1'b1; in_port = 32'hA;
    @(negedge clk);
    cfg_mask_upd = 1'b0;
    n = bus_log.size();
    evt_ready = 1'b1;
    for (int i = 0; i < 100 && bus_log.size() < n + 2; i++) @(negedge clk);
    chk("mu_wr_mask", log_at(n), {28'h0, 1'b1, 3'd2, 32'h0F});
    chk("mu_wr_clr", log_at(n + 1), {28'h0, 1'b1, 3'd3, 32'hFFFF_FFFF});
    chk("mu_count", evt_count, 4);
    chk("mu_data", evt_at(3), 32'h8);

    // 6: reset during PUSH
    repeat (10) @(negedge clk);
    evt_ready = 1'b0;
    in_port = 32'h0;
    repeat (3) @(negedge clk);
    in_port = 32'h8;
    for (int i = 0; i < 100 && !evt_valid; i++) @(negedge clk);
    chk("rp_valid_before", evt_valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rp_valid", evt_valid, 0);
    chk("rp_count", evt_count, 0);
    reset_n = 1'b1;
    n = bus_log.size();
    for (int i = 0; i < 50 && bus_log.size() < n + 2; i++) @(negedge clk);
    chk("rp_wr_mask", log_at(n), {28'h0, 1'b1, 3'd2, 32'h0F});
    chk("rp_wr_clr", log_at(n + 1), {28'h0, 1'b1, 3'd3, 32'hFFFF_FFFF});
    chk("rp_nevt", evt_log.size(), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
